sync_fifo_ctl: RTL

Parametrised single-clock FIFO with a standard or first-word-fall-through read mode, non-power-of-two depth, occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow pulses. It is the general buffering primitive between accelerator stages and feeds data, weights and instructions between producer and consumer pipelines. Storage is a synchronous-read dual-port RAM with one write port and one read port, inferred inside the block.

---
 rtl/sync_fifo_ctl.sv | 97 +++++++++
 1 files changed

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller around an inferred synchronous-read dual-port RAM.
// Supports standard or first-word-fall-through reads, an occupancy count and threshold flags.
module sync_fifo_ctl #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = CNT_W'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = CNT_W'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;
  logic                  ram_has_word;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign full         = (count == DEPTH_CNT);
  assign empty        = FWFT ? !valid : (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // In FWFT mode count also covers the word parked in data_out, so the RAM
  // holds count - valid words; prefetch whenever the output slot frees up.
  always_comb begin
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
    ram_has_word = (count > {{ADDR_WIDTH{1'b0}}, valid});
    ram_rd       = FWFT ? (ram_has_word && (!valid || rd_acc)) : rd_acc;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (ram_rd) begin
        rd_ptr   <= next_ptr(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (FWFT) begin
        valid <= ram_rd || (valid && !rd_acc);
      end else begin
        valid <= rd_acc;
      end
    end
  end

endmodule
